// File: rtl/spi_regs_pkg.sv
// Shared address map defaults and helpers for the SPI register bank.
package spi_regs_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 7;
  localparam int unsigned DEF_NUM_RW = 16;
  localparam int unsigned DEF_NUM_RO = 8;
  localparam int unsigned DEF_IRQ_W  = 8;

  localparam logic [6:0] DEF_RO_BASE         = 7'h20;
  localparam logic [6:0] DEF_IRQ_STATUS_ADDR = 7'h1E;
  localparam logic [6:0] DEF_IRQ_MASK_ADDR   = 7'h1F;
  localparam logic [7:0] DEF_UNMAPPED_VAL    = 8'h99;

  // Named indices of the read/write registers.
  typedef enum int unsigned {
    RW_CTRL    = 0,
    RW_MODE    = 1,
    RW_LED     = 2,
    RW_GPIO_O  = 3,
    RW_GPIO_OE = 4,
    RW_PWM0    = 5,
    RW_PWM1    = 6,
    RW_PWM2    = 7,
    RW_PWM3    = 8,
    RW_DIV_LO  = 9,
    RW_DIV_HI  = 10,
    RW_CFG0    = 11,
    RW_CFG1    = 12,
    RW_CFG2    = 13,
    RW_CFG3    = 14,
    RW_SCRATCH = 15
  } rw_reg_e;

  // True when address a lies in [base, base+n).
  function automatic bit addr_in_window(input int unsigned a, input int unsigned base,
                                        input int unsigned n);
    return (a >= base) && (a < base + n);
  endfunction

  // True when [b0, b0+n0) and [b1, b1+n1) share any address.
  function automatic bit windows_overlap(input int unsigned b0, input int unsigned n0,
                                         input int unsigned b1, input int unsigned n1);
    return (n0 != 0) && (n1 != 0) && (b0 < b1 + n1) && (b1 < b0 + n0);
  endfunction

endpackage

// File: rtl/spi_reg_bank_irq_capture.sv
// Edge-insensitive change detector feeding a sticky, masked, clear-on-read status.
module irq_capture #(
  parameter int unsigned IRQ_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IRQ_W-1:0] irq_in_i,
  input  logic             mask_wr_i,
  input  logic [IRQ_W-1:0] mask_wdata_i,
  input  logic             status_rd_i,
  output logic [IRQ_W-1:0] status_o,
  output logic [IRQ_W-1:0] mask_o,
  output logic             irq_o
);

  logic             armed_q;
  logic [IRQ_W-1:0] irq_prev_q;
  logic [IRQ_W-1:0] status_q, status_d;
  logic [IRQ_W-1:0] mask_q, mask_d;
  logic             irq_q;
  logic [IRQ_W-1:0] event_c;
  logic [IRQ_W-1:0] clr_c;

  // Event detect and status merge; a same-cycle event survives the read clear.
  always_comb begin
    event_c  = '0;
    clr_c    = '0;
    mask_d   = mask_q;
    if (armed_q) begin
      event_c = irq_in_i ^ irq_prev_q;
    end
    if (status_rd_i) begin
      clr_c = status_q;
    end
    status_d = (status_q & ~clr_c) | event_c;
    if (mask_wr_i) begin
      mask_d = mask_wdata_i;
    end
  end

  // State registers; armed_q suppresses the bogus event on the first cycle after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q    <= 1'b0;
      irq_prev_q <= '0;
      status_q   <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      armed_q    <= 1'b1;
      irq_prev_q <= irq_in_i;
      status_q   <= status_d;
      mask_q     <= mask_d;
      irq_q      <= |(status_q & mask_q);
    end
  end

  assign status_o = status_q;
  assign mask_o   = mask_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-facing register bank: address pointer, decode, RW array, read mux and IRQ block.
module spi_reg_bank
  import spi_regs_pkg::*;
#(
  parameter int unsigned              DATA_W          = DEF_DATA_W,
  parameter int unsigned              ADDR_W          = DEF_ADDR_W,
  parameter int unsigned              NUM_RW          = DEF_NUM_RW,
  parameter int unsigned              NUM_RO          = DEF_NUM_RO,
  parameter logic [ADDR_W-1:0]        RO_BASE         = ADDR_W'(DEF_RO_BASE),
  parameter int unsigned              IRQ_W           = DEF_IRQ_W,
  parameter logic [ADDR_W-1:0]        IRQ_STATUS_ADDR = ADDR_W'(DEF_IRQ_STATUS_ADDR),
  parameter logic [ADDR_W-1:0]        IRQ_MASK_ADDR   = ADDR_W'(DEF_IRQ_MASK_ADDR),
  parameter bit                       AUTO_INC        = 1'b1,
  parameter logic [DATA_W-1:0]        UNMAPPED_VAL    = DATA_W'(DEF_UNMAPPED_VAL)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_cs0,
  input  logic                     rd_strobe,
  input  logic                     wr_strobe,
  input  logic [ADDR_W-1:0]        spi_addr,
  input  logic [DATA_W-1:0]        spi_write_data,
  output logic [DATA_W-1:0]        spi_read_data,
  input  logic [NUM_RO*DATA_W-1:0] ro_regs,
  output logic [NUM_RW*DATA_W-1:0] rw_regs,
  output logic [NUM_RW-1:0]        reg_wr_stb,
  output logic [NUM_RO-1:0]        ro_rd_stb,
  input  logic [IRQ_W-1:0]         irq_in,
  output logic                     irq,
  output logic [ADDR_W-1:0]        cur_addr
);

  localparam int unsigned RW_IDX_W = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;
  localparam int unsigned RO_IDX_W = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;
  localparam int unsigned STS_A    = 32'(IRQ_STATUS_ADDR);
  localparam int unsigned MSK_A    = 32'(IRQ_MASK_ADDR);
  localparam int unsigned RO_A     = 32'(RO_BASE);

  // Reject parameter sets whose address windows alias each other.
  if (IRQ_W > DATA_W) begin : g_bad_irq_w
    $error("spi_reg_bank: IRQ_W must not exceed DATA_W");
  end
  if (windows_overlap(0, NUM_RW, RO_A, NUM_RO)) begin : g_bad_rw_ro
    $error("spi_reg_bank: RW window overlaps RO window");
  end
  if (addr_in_window(STS_A, 0, NUM_RW) || addr_in_window(STS_A, RO_A, NUM_RO) ||
      addr_in_window(MSK_A, 0, NUM_RW) || addr_in_window(MSK_A, RO_A, NUM_RO) ||
      (STS_A == MSK_A)) begin : g_bad_irq_addr
    $error("spi_reg_bank: IRQ register address aliases another register");
  end
  if (RO_A + NUM_RO > (32'd1 << ADDR_W) || NUM_RW > (32'd1 << ADDR_W)) begin : g_bad_range
    $error("spi_reg_bank: register window exceeds address space");
  end

  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                ptr_valid_q, ptr_valid_d;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [ADDR_W-1:0]   eff_c;
  logic                any_stb_c, wr_act_c, rd_act_c;
  logic                rw_hit_c, ro_hit_c, mask_hit_c, status_hit_c;
  logic [RW_IDX_W-1:0] rw_idx_c;
  logic [RO_IDX_W-1:0] ro_idx_c;
  logic [DATA_W-1:0]   rd_val_c;
  logic [NUM_RW-1:0]   reg_wr_stb_q, reg_wr_stb_d;
  logic [NUM_RO-1:0]   ro_rd_stb_q, ro_rd_stb_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   rw_q [NUM_RW];
  logic [DATA_W-1:0]   ro_arr [NUM_RO];
  logic [IRQ_W-1:0]    irq_status, irq_mask;

  // Unpack the flattened RO inputs and pack the RW array back out.
  for (genvar k = 0; k < NUM_RO; k++) begin : g_ro
    assign ro_arr[k] = ro_regs[k*DATA_W +: DATA_W];
  end
  for (genvar k = 0; k < NUM_RW; k++) begin : g_rw
    assign rw_regs[k*DATA_W +: DATA_W] = rw_q[k];
  end

  // Effective address, decode, pointer update and read mux.
  always_comb begin
    any_stb_c    = rd_strobe | wr_strobe;
    wr_act_c     = wr_strobe;
    rd_act_c     = rd_strobe & ~wr_strobe;
    eff_c        = (AUTO_INC && ptr_valid_q) ? ptr_q : spi_addr;
    rw_hit_c     = 32'(eff_c) < NUM_RW;
    ro_hit_c     = addr_in_window(32'(eff_c), RO_A, NUM_RO);
    mask_hit_c   = eff_c == IRQ_MASK_ADDR;
    status_hit_c = eff_c == IRQ_STATUS_ADDR;
    rw_idx_c     = RW_IDX_W'(eff_c);
    ro_idx_c     = RO_IDX_W'(eff_c - RO_BASE);
    ptr_d        = ptr_q;
    ptr_valid_d  = ptr_valid_q;
    reg_wr_stb_d = '0;
    ro_rd_stb_d  = '0;
    rd_val_c     = UNMAPPED_VAL;

    if (any_stb_c) begin
      ptr_d       = eff_c + ADDR_W'(1);
      ptr_valid_d = AUTO_INC;
    end
    if (spi_cs0) begin
      ptr_valid_d = 1'b0;
    end

    if (wr_act_c && rw_hit_c) begin
      reg_wr_stb_d[rw_idx_c] = 1'b1;
    end
    if (rd_act_c && ro_hit_c) begin
      ro_rd_stb_d[ro_idx_c] = 1'b1;
    end

    if (rw_hit_c) begin
      rd_val_c = rw_q[rw_idx_c];
    end else if (ro_hit_c) begin
      rd_val_c = ro_arr[ro_idx_c];
    end else if (mask_hit_c) begin
      rd_val_c = DATA_W'(irq_mask);
    end else if (status_hit_c) begin
      rd_val_c = DATA_W'(irq_status);
    end
  end

  // Pointer, strobes, register array and read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= '0;
      ptr_valid_q  <= 1'b0;
      cur_addr_q   <= '0;
      reg_wr_stb_q <= '0;
      ro_rd_stb_q  <= '0;
      rd_data_q    <= '0;
      for (int k = 0; k < NUM_RW; k++) begin
        rw_q[k] <= '0;
      end
    end else begin
      ptr_q        <= ptr_d;
      ptr_valid_q  <= ptr_valid_d;
      reg_wr_stb_q <= reg_wr_stb_d;
      ro_rd_stb_q  <= ro_rd_stb_d;
      if (any_stb_c) begin
        cur_addr_q <= eff_c;
      end
      if (wr_act_c && rw_hit_c) begin
        rw_q[rw_idx_c] <= spi_write_data;
      end
      if (rd_act_c) begin
        rd_data_q <= rd_val_c;
      end
    end
  end

  irq_capture #(
    .IRQ_W (IRQ_W)
  ) u_irq (
    .clk          (clk),
    .reset        (reset),
    .irq_in_i     (irq_in),
    .mask_wr_i    (wr_act_c & mask_hit_c),
    .mask_wdata_i (spi_write_data[IRQ_W-1:0]),
    .status_rd_i  (rd_act_c & status_hit_c),
    .status_o     (irq_status),
    .mask_o       (irq_mask),
    .irq_o        (irq)
  );

  assign spi_read_data = rd_data_q;
  assign reg_wr_stb    = reg_wr_stb_q;
  assign ro_rd_stb     = ro_rd_stb_q;
  assign cur_addr      = cur_addr_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: vector table plus hand-written multi-cycle sequences.
module tb_spi_reg_bank;

  logic         clk = 1'b0;
  logic         reset;
  logic         spi_cs0;
  logic         rd_strobe;
  logic         wr_strobe;
  logic [6:0]   spi_addr;
  logic [7:0]   spi_write_data;
  logic [7:0]   spi_read_data;
  logic [63:0]  ro_regs;
  logic [127:0] rw_regs;
  logic [15:0]  reg_wr_stb;
  logic [7:0]   ro_rd_stb;
  logic [7:0]   irq_in;
  logic         irq;
  logic [6:0]   cur_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_reg_bank dut (
    .clk            (clk),
    .reset          (reset),
    .spi_cs0        (spi_cs0),
    .rd_strobe      (rd_strobe),
    .wr_strobe      (wr_strobe),
    .spi_addr       (spi_addr),
    .spi_write_data (spi_write_data),
    .spi_read_data  (spi_read_data),
    .ro_regs        (ro_regs),
    .rw_regs        (rw_regs),
    .reg_wr_stb     (reg_wr_stb),
    .ro_rd_stb      (ro_rd_stb),
    .irq_in         (irq_in),
    .irq            (irq),
    .cur_addr       (cur_addr)
  );

  typedef struct {
    bit         is_wr;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    logic [15:0] exp_wstb;
    logic [7:0] exp_rstb;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rw(input int a);
    return rw_regs[a*8 +: 8];
  endfunction

  // One-cycle strobe; returns on the falling edge after the capturing edge.
  task automatic strobe(input bit rd, input bit wr, input logic [6:0] a, input logic [7:0] d);
    spi_addr       = a;
    spi_write_data = d;
    rd_strobe      = rd;
    wr_strobe      = wr;
    @(negedge clk);
    rd_strobe = 1'b0;
    wr_strobe = 1'b0;
  endtask

  task automatic frame_end();
    spi_cs0 = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 7'h03, 8'hA5, 8'hA5, 16'h0008, 8'h00};
    vecs[1]  = '{1'b0, 7'h03, 8'h00, 8'hA5, 16'h0000, 8'h00};
    vecs[2]  = '{1'b1, 7'h00, 8'h01, 8'h01, 16'h0001, 8'h00};
    vecs[3]  = '{1'b1, 7'h0F, 8'hF0, 8'hF0, 16'h8000, 8'h00};
    vecs[4]  = '{1'b0, 7'h22, 8'h00, 8'hC2, 16'h0000, 8'h04};
    vecs[5]  = '{1'b0, 7'h27, 8'h00, 8'hC7, 16'h0000, 8'h80};
    vecs[6]  = '{1'b0, 7'h50, 8'h00, 8'h99, 16'h0000, 8'h00};
    vecs[7]  = '{1'b1, 7'h20, 8'h33, 8'h00, 16'h0000, 8'h00};
    vecs[8]  = '{1'b1, 7'h10, 8'h77, 8'h00, 16'h0000, 8'h00};
    vecs[9]  = '{1'b0, 7'h10, 8'h00, 8'h99, 16'h0000, 8'h00};
    vecs[10] = '{1'b0, 7'h0F, 8'h00, 8'hF0, 16'h0000, 8'h00};
    vecs[11] = '{1'b0, 7'h1F, 8'h00, 8'h00, 16'h0000, 8'h00};
    vecs[12] = '{1'b1, 7'h1E, 8'h55, 8'h00, 16'h0000, 8'h00};
    vecs[13] = '{1'b0, 7'h1E, 8'h00, 8'h00, 16'h0000, 8'h00};

    reset          = 1'b1;
    spi_cs0        = 1'b1;
    rd_strobe      = 1'b0;
    wr_strobe      = 1'b0;
    spi_addr       = '0;
    spi_write_data = '0;
    irq_in         = '0;
    for (int k = 0; k < 8; k++) ro_regs[k*8 +: 8] = 8'hC0 + 8'(k);

    repeat (2) @(negedge clk);
    chk("rst_rw_regs", {31'b0, |rw_regs}, 0);
    chk("rst_rd_data", {24'b0, spi_read_data}, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    chk("rst_cur_addr", {25'b0, cur_addr}, 0);
    chk("rst_strobes", {8'b0, reg_wr_stb, ro_rd_stb}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single accesses, one per frame.
    for (int i = 0; i < NV; i++) begin
      spi_cs0 = 1'b0;
      strobe(!vecs[i].is_wr, vecs[i].is_wr, vecs[i].addr, vecs[i].data);
      chk($sformatf("v%0d_cur_addr", i), {25'b0, cur_addr}, {25'b0, vecs[i].addr});
      chk($sformatf("v%0d_wstb", i), {16'b0, reg_wr_stb}, {16'b0, vecs[i].exp_wstb});
      chk($sformatf("v%0d_rstb", i), {24'b0, ro_rd_stb}, {24'b0, vecs[i].exp_rstb});
      if (vecs[i].is_wr) begin
        if (vecs[i].addr < 7'h10)
          chk($sformatf("v%0d_reg", i), {24'b0, rw(int'(vecs[i].addr))}, {24'b0, vecs[i].exp});
      end else begin
        chk($sformatf("v%0d_rdata", i), {24'b0, spi_read_data}, {24'b0, vecs[i].exp});
      end
      frame_end();
      chk($sformatf("v%0d_stb_cleared", i), {8'b0, reg_wr_stb, ro_rd_stb}, 0);
    end

    // Burst write with auto-increment, then a fresh frame restarts at spi_addr.
    spi_cs0 = 1'b0;
    strobe(1'b0, 1'b1, 7'h02, 8'h11);
    strobe(1'b0, 1'b1, 7'h02, 8'h22);
    strobe(1'b0, 1'b1, 7'h02, 8'h33);
    chk("burst_cur_addr", {25'b0, cur_addr}, 32'h4);
    frame_end();
    chk("burst_r2", {24'b0, rw(2)}, 32'h11);
    chk("burst_r3", {24'b0, rw(3)}, 32'h22);
    chk("burst_r4", {24'b0, rw(4)}, 32'h33);
    spi_cs0 = 1'b0;
    strobe(1'b0, 1'b1, 7'h02, 8'h44);
    frame_end();
    chk("refr_r2", {24'b0, rw(2)}, 32'h44);
    chk("refr_r3", {24'b0, rw(3)}, 32'h22);

    // Pointer wrap from 7F to 0.
    spi_cs0 = 1'b0;
    strobe(1'b1, 1'b0, 7'h7F, 8'h00);
    chk("wrap0_addr", {25'b0, cur_addr}, 32'h7F);
    chk("wrap0_data", {24'b0, spi_read_data}, 32'h99);
    chk("wrap0_rstb", {24'b0, ro_rd_stb}, 0);
    strobe(1'b1, 1'b0, 7'h7F, 8'h00);
    chk("wrap1_addr", {25'b0, cur_addr}, 32'h0);
    chk("wrap1_data", {24'b0, spi_read_data}, 32'h01);
    frame_end();

    // Simultaneous read and write: write wins, pointer advances once.
    spi_cs0 = 1'b0;
    strobe(1'b1, 1'b1, 7'h05, 8'h5A);
    chk("sim_r5", {24'b0, rw(5)}, 32'h5A);
    chk("sim_wstb", {16'b0, reg_wr_stb}, 32'h0020);
    chk("sim_rdata_held", {24'b0, spi_read_data}, 32'h01);
    strobe(1'b1, 1'b0, 7'h05, 8'h00);
    chk("sim_next_addr", {25'b0, cur_addr}, 32'h6);
    chk("sim_next_data", {24'b0, spi_read_data}, 32'h00);
    frame_end();

    // Masked interrupt, unmask, clear-on-read.
    irq_in = 8'h02;
    repeat (3) @(negedge clk);
    chk("irq_masked", {31'b0, irq}, 0);
    spi_cs0 = 1'b0;
    strobe(1'b0, 1'b1, 7'h1F, 8'h02);
    frame_end();
    chk("irq_unmasked", {31'b0, irq}, 1);
    spi_cs0 = 1'b0;
    strobe(1'b1, 1'b0, 7'h1E, 8'h00);
    chk("sts_read", {24'b0, spi_read_data}, 32'h02);
    frame_end();
    chk("irq_cleared", {31'b0, irq}, 0);
    spi_cs0 = 1'b0;
    strobe(1'b1, 1'b0, 7'h1E, 8'h00);
    chk("sts_after_clear", {24'b0, spi_read_data}, 32'h00);
    frame_end();

    // Event landing on the same edge as the status read is kept.
    spi_cs0 = 1'b0;
    irq_in  = 8'h03;
    strobe(1'b1, 1'b0, 7'h1E, 8'h00);
    chk("evclr_read", {24'b0, spi_read_data}, 32'h00);
    frame_end();
    spi_cs0 = 1'b0;
    strobe(1'b1, 1'b0, 7'h1E, 8'h00);
    chk("evclr_kept", {24'b0, spi_read_data}, 32'h01);
    frame_end();
    chk("evclr_irq", {31'b0, irq}, 0);

    // Reset mid-burst with all sources high; no event after release.
    spi_cs0 = 1'b0;
    irq_in  = 8'hFF;
    strobe(1'b0, 1'b1, 7'h08, 8'h12);
    wr_strobe      = 1'b1;
    spi_write_data = 8'h34;
    reset          = 1'b1;
    #1;
    chk("mrst_rw_regs", {31'b0, |rw_regs}, 0);
    chk("mrst_rd_data", {24'b0, spi_read_data}, 0);
    chk("mrst_irq", {31'b0, irq}, 0);
    chk("mrst_cur_addr", {25'b0, cur_addr}, 0);
    chk("mrst_strobes", {8'b0, reg_wr_stb, ro_rd_stb}, 0);
    @(negedge clk);
    chk("mrst_wr_ignored", {31'b0, |rw_regs}, 0);
    wr_strobe = 1'b0;
    spi_cs0   = 1'b1;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    spi_cs0 = 1'b0;
    strobe(1'b1, 1'b0, 7'h1E, 8'h00);
    chk("post_rst_sts", {24'b0, spi_read_data}, 32'h00);
    frame_end();
    spi_cs0 = 1'b0;
    strobe(1'b1, 1'b0, 7'h1F, 8'h00);
    chk("post_rst_mask", {24'b0, spi_read_data}, 32'h00);
    frame_end();
    irq_in = 8'h7F;
    @(negedge clk);
    spi_cs0 = 1'b0;
    strobe(1'b1, 1'b0, 7'h1E, 8'h00);
    chk("post_rst_event", {24'b0, spi_read_data}, 32'h80);
    frame_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
